// File: rtl/host_mmio_bridge.sv
// Core-facing tohost/fromhost endpoint: a TOHOST FIFO drained over valid/ready,
// a single-word FROMHOST holding register, and a status/control register window.
module host_mmio_bridge #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        host_write_enable,
    output logic [31:0] host_data_out,
    input  logic        host_ready,
    input  logic        fromhost_valid,
    input  logic [31:0] fromhost_data,
    output logic        fromhost_ready,
    output logic        irq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ADDR_TOHOST   = 2'd0;
    localparam logic [1:0] ADDR_FROMHOST = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_CTRL     = 2'd3;

    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             overflow_r;
    logic             overflow_nxt_s;
    logic             fh_full_r;
    logic             fh_full_nxt_s;
    logic [31:0]      fh_data_r;
    logic             irq_en_r;
    logic             irq_r;
    logic [31:0]      rdata_r;
    logic [31:0]      rdata_nxt_s;

    logic bus_wr_s;
    logic bus_rd_s;
    logic push_s;
    logic pop_s;
    logic push_ok_s;
    logic overflow_set_s;
    logic fifo_empty_s;
    logic fifo_full_s;
    logic capture_s;
    logic fh_clear_s;
    logic status_clr_s;

    // STATUS layout: count in [8:4], sticky overflow, FIFO flags, fromhost_full.
    function automatic logic [31:0] pack_status(
        input logic [CNT_W-1:0] cnt,
        input logic             ovf,
        input logic             empty,
        input logic             full,
        input logic             fh_full
    );
        logic [4:0] cnt_field;
        cnt_field = 5'(cnt);
        pack_status = {23'd0, cnt_field, ovf, empty, full, fh_full};
    endfunction

    assign bus_wr_s       = sel & we;
    assign bus_rd_s       = sel & re;
    assign fifo_empty_s   = (count_r == {CNT_W{1'b0}});
    assign fifo_full_s    = (count_r == DEPTH_C);
    assign push_s         = bus_wr_s & (addr == ADDR_TOHOST);
    assign pop_s          = ~fifo_empty_s & host_ready;
    // A push into a full FIFO is still accepted when the head leaves in the same edge.
    assign push_ok_s      = push_s & (~fifo_full_s | pop_s);
    assign overflow_set_s = push_s & ~push_ok_s;
    assign capture_s      = fromhost_valid & ~fh_full_r;
    assign fh_clear_s     = bus_rd_s & (addr == ADDR_FROMHOST) & fh_full_r;
    assign status_clr_s   = bus_wr_s & (addr == ADDR_STATUS) & wdata[3];

    // Next occupancy count.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next sticky overflow and fromhost_full flags; a new overflow beats a W1C clear.
    always_comb begin
        overflow_nxt_s = overflow_r;
        fh_full_nxt_s  = fh_full_r;
        if (overflow_set_s) begin
            overflow_nxt_s = 1'b1;
        end else if (status_clr_s) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
        if (fh_clear_s) begin
            fh_full_nxt_s = 1'b0;
        end else if (capture_s) begin
            fh_full_nxt_s = 1'b1;
        end else begin
            fh_full_nxt_s = fh_full_r;
        end
    end

    // Read data mux; rdata holds its value between reads.
    always_comb begin
        rdata_nxt_s = rdata_r;
        if (bus_rd_s) begin
            case (addr)
                ADDR_TOHOST:   rdata_nxt_s = 32'd0;
                ADDR_FROMHOST: rdata_nxt_s = fh_data_r;
                ADDR_STATUS:   rdata_nxt_s = pack_status(count_r, overflow_r, fifo_empty_s,
                                                         fifo_full_s, fh_full_r);
                ADDR_CTRL:     rdata_nxt_s = {31'd0, irq_en_r};
                default:       rdata_nxt_s = 32'd0;
            endcase
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // Tohost FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Control/status registers, fromhost holding register, read data and interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
            fh_full_r  <= 1'b0;
            fh_data_r  <= 32'd0;
            irq_en_r   <= 1'b0;
            irq_r      <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            overflow_r <= overflow_nxt_s;
            fh_full_r  <= fh_full_nxt_s;
            if (capture_s) begin
                fh_data_r <= fromhost_data;
            end
            if (bus_wr_s && (addr == ADDR_CTRL)) begin
                irq_en_r <= wdata[0];
            end
            irq_r   <= irq_en_r & fh_full_r;
            rdata_r <= rdata_nxt_s;
        end
    end

    assign rdata             = rdata_r;
    assign host_write_enable = ~fifo_empty_s;
    assign host_data_out     = fifo_empty_s ? 32'd0 : mem_r[rd_ptr_r];
    assign fromhost_ready    = ~fh_full_r;
    assign irq               = irq_r;

endmodule
